// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage bridging the core datapath to a valid/ready data bus.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  readMemory,
    input  logic                  writeMemory,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           writeData,
    output logic [31:0]           readData,
    output logic                  stall,
    output logic                  busRequest,
    output logic                  busWrite,
    output logic [ADDR_WIDTH-1:0] busAddress,
    output logic [3:0]            busByteEnable,
    output logic [31:0]           busWriteData,
    input  logic                  busReady,
    input  logic [31:0]           busReadData,
    output logic                  busError,
    output logic                  misaligned
);

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        DONE
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                  state_q;
    logic [7:0]              counter_q;
    logic [2:0]              funct3_q;
    logic [1:0]              offset_q;
    logic [ADDR_WIDTH-1:0]   busAddress_q;
    logic                    busWrite_q;
    logic [3:0]              busByteEnable_q;
    logic [31:0]             busWriteData_q;
    logic [31:0]             readData_q;
    logic                    busError_q;
    logic                    misaligned_q;

    logic                    accessRequested;
    logic                    isByte;
    logic                    isHalf;
    logic [3:0]              byteEnable_d;
    logic [31:0]             writeData_d;
    logic                    misalign_d;
    logic [7:0]              loadByte;
    logic [15:0]             loadHalf;
    logic [31:0]             loadValue_d;

    assign accessRequested = readMemory | writeMemory;

    // funct3[1:0] alone decides size: 0/4 are bytes, 1/5 halves, everything else a word.
    always_comb begin
        isByte       = (funct3[1:0] == 2'b00);
        isHalf       = (funct3[1:0] == 2'b01);
        byteEnable_d = 4'b1111;
        writeData_d  = writeData;
        misalign_d   = 1'b0;
        if (isByte) begin
            byteEnable_d = 4'b0001 << address[1:0];
            writeData_d  = {4{writeData[7:0]}};
        end else if (isHalf) begin
            byteEnable_d = address[1] ? 4'b1100 : 4'b0011;
            writeData_d  = {2{writeData[15:0]}};
        end
`ifdef LSU_MISALIGN_TRAP_EN
        if (isHalf) begin
            misalign_d = address[0];
        end else if (!isByte) begin
            misalign_d = (address[1:0] != 2'b00);
        end
`endif
    end

    always_comb begin
        loadByte    = busReadData[{offset_q, 3'b000} +: 8];
        loadHalf    = offset_q[1] ? busReadData[31:16] : busReadData[15:0];
        loadValue_d = busReadData;
        case (funct3_q)
            3'd0:    loadValue_d = {{24{loadByte[7]}}, loadByte};
            3'd4:    loadValue_d = {24'd0, loadByte};
            3'd1:    loadValue_d = {{16{loadHalf[15]}}, loadHalf};
            3'd5:    loadValue_d = {16'd0, loadHalf};
            default: loadValue_d = busReadData;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            counter_q       <= 8'd0;
            funct3_q        <= 3'd0;
            offset_q        <= 2'd0;
            busAddress_q    <= '0;
            busWrite_q      <= 1'b0;
            busByteEnable_q <= 4'd0;
            busWriteData_q  <= 32'd0;
            readData_q      <= 32'd0;
            busError_q      <= 1'b0;
            misaligned_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accessRequested) begin
                        funct3_q  <= funct3;
                        offset_q  <= address[1:0];
                        counter_q <= 8'd0;
                        if (misalign_d) begin
                            misaligned_q <= 1'b1;
                            readData_q   <= 32'd0;
                            state_q      <= DONE;
                        end else begin
                            busAddress_q    <= {address[ADDR_WIDTH-1:2], 2'b00};
                            busWrite_q      <= writeMemory;
                            busByteEnable_q <= byteEnable_d;
                            busWriteData_q  <= writeData_d;
                            state_q         <= REQUEST;
                        end
                    end
                end
                REQUEST: begin
                    if (busReady) begin
                        if (!busWrite_q) begin
                            readData_q <= loadValue_d;
                        end
                        state_q <= DONE;
                    end else if (counter_q == TIMEOUT_LAST) begin
                        readData_q <= 32'd0;
                        busError_q <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        counter_q <= counter_q + 8'd1;
                    end
                end
                DONE: begin
                    // Enables still show the same instruction here, so they are ignored.
                    busError_q   <= 1'b0;
                    misaligned_q <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall         = !reset && ((state_q == IDLE && accessRequested) || state_q == REQUEST);
    assign busRequest    = (state_q == REQUEST);
    assign busWrite      = busWrite_q;
    assign busAddress    = busAddress_q;
    assign busByteEnable = busByteEnable_q;
    assign busWriteData  = busWriteData_q;
    assign readData      = readData_q;
    assign busError      = busError_q;
    assign misaligned    = misaligned_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed plan steps plus random accesses
// compared against a byte-lane arithmetic reference model.
module tb_load_store_unit;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        readMemory;
    logic        writeMemory;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        stall;
    logic        busRequest;
    logic        busWrite;
    logic [31:0] busAddress;
    logic [3:0]  busByteEnable;
    logic [31:0] busWriteData;
    logic        busReady;
    logic [31:0] busReadData;
    logic        busError;
    logic        misaligned;

    int          testsRun = 0;
    int          testsFailed = 0;
    logic [31:0] expRead;
    logic [31:0] obsAddr;
    logic [3:0]  obsBE;
    logic [31:0] obsWD;
    logic        obsWrite;
    int          obsReqCycles;

    load_store_unit #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .ADDR_WIDTH(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .readMemory(readMemory),
        .writeMemory(writeMemory),
        .funct3(funct3),
        .address(address),
        .writeData(writeData),
        .readData(readData),
        .stall(stall),
        .busRequest(busRequest),
        .busWrite(busWrite),
        .busAddress(busAddress),
        .busByteEnable(busByteEnable),
        .busWriteData(busWriteData),
        .busReady(busReady),
        .busReadData(busReadData),
        .busError(busError),
        .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic int accessSize(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit modelMisaligned(input logic [2:0] f3, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
        return (int'(addr % 4) % accessSize(f3)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int laneOffset(input logic [2:0] f3, input logic [31:0] addr);
        int sz = accessSize(f3);
        return (int'(addr % 4) / sz) * sz;
    endfunction

    function automatic logic [3:0] modelEnable(input logic [2:0] f3, input logic [31:0] addr);
        int mask = (1 << accessSize(f3)) - 1;
        return 4'(mask << laneOffset(f3, addr));
    endfunction

    function automatic logic [31:0] modelStoreData(input logic [2:0] f3, input logic [31:0] wdata);
        logic [31:0] r;
        int sz = accessSize(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wdata[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] raw);
        int sz = accessSize(f3);
        longint unsigned mask;
        longint unsigned v;
        if (sz == 4) return raw;
        mask = (64'd1 << (8 * sz)) - 64'd1;
        v = (longint'(raw) >> (8 * laneOffset(f3, addr))) & mask;
        if ((f3 == 3'd0 || f3 == 3'd1) && v >= (mask + 64'd1) / 2) v = v | ~mask;
        return v[31:0];
    endfunction

    // One full access from IDLE through DONE and back to IDLE; called just after a falling edge.
    task automatic applyStimulus(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int readyDelay, input logic [31:0] raw,
                                 input string tag);
        bit mis = modelMisaligned(f3, addr);
        bit expErr = !mis && (readyDelay >= TIMEOUT);
        int expCycles = mis ? 0 : ((readyDelay < TIMEOUT) ? readyDelay + 1 : TIMEOUT);
        bit done = 1'b0;
        readMemory  = rd;
        writeMemory = wr;
        funct3      = f3;
        address     = addr;
        writeData   = wdata;
        busReady    = 1'b0;
        busReadData = raw;
        #1;
        checkOutput({tag, " stallIdle"}, 32'(stall), 32'd1);
        obsReqCycles = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (busRequest) begin
                if (obsReqCycles == 0) begin
                    obsAddr  = busAddress;
                    obsBE    = busByteEnable;
                    obsWD    = busWriteData;
                    obsWrite = busWrite;
                    checkOutput({tag, " busAddress"}, busAddress, addr & 32'hFFFF_FFFC);
                    checkOutput({tag, " byteEnable"}, 32'(busByteEnable), 32'(modelEnable(f3, addr)));
                    checkOutput({tag, " busWrite"}, 32'(busWrite), 32'(wr));
                    if (wr) checkOutput({tag, " busWriteData"}, busWriteData, modelStoreData(f3, wdata));
                end
                checkOutput({tag, " stallReq"}, 32'(stall), 32'd1);
                busReady = (obsReqCycles == readyDelay);
                obsReqCycles++;
            end else begin
                done = 1'b1;
            end
        end
        checkOutput({tag, " reachedDone"}, 32'(done), 32'd1);
        if (mis || expErr) expRead = 32'd0;
        else if (!wr) expRead = modelLoad(f3, addr, raw);
        checkOutput({tag, " reqCycles"}, 32'(obsReqCycles), 32'(expCycles));
        checkOutput({tag, " stallDone"}, 32'(stall), 32'd0);
        checkOutput({tag, " readData"}, readData, expRead);
        checkOutput({tag, " busError"}, 32'(busError), 32'(expErr));
        checkOutput({tag, " misaligned"}, 32'(misaligned), 32'(mis));
        readMemory  = 1'b0;
        writeMemory = 1'b0;
        busReady    = 1'b0;
        @(negedge clk);
        checkOutput({tag, " busErrorClear"}, 32'(busError), 32'd0);
        checkOutput({tag, " misalignedClear"}, 32'(misaligned), 32'd0);
        checkOutput({tag, " readDataHeld"}, readData, expRead);
    endtask

    initial begin
        reset       = 1'b1;
        readMemory  = 1'b0;
        writeMemory = 1'b0;
        funct3      = 3'd0;
        address     = 32'd0;
        writeData   = 32'd0;
        busReady    = 1'b0;
        busReadData = 32'd0;
        expRead     = 32'd0;
        #1;
        checkOutput("reset readData", readData, 32'd0);
        checkOutput("reset stall", 32'(stall), 32'd0);
        checkOutput("reset busRequest", 32'(busRequest), 32'd0);
        checkOutput("reset busAddress", busAddress, 32'd0);
        checkOutput("reset byteEnable", 32'(busByteEnable), 32'd0);
        checkOutput("reset busError", 32'(busError), 32'd0);
        checkOutput("reset misaligned", 32'(misaligned), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(1, 0, 3'd2, 32'h100, 32'd0, 0, 32'hDEAD_BEEF, "LW");
        checkOutput("LW addr", obsAddr, 32'h100);
        checkOutput("LW be", 32'(obsBE), 32'hF);
        checkOutput("LW cycles", 32'(obsReqCycles), 32'd1);
        checkOutput("LW data", readData, 32'hDEAD_BEEF);

        applyStimulus(1, 0, 3'd0, 32'h103, 32'd0, 1, 32'h80FF_0000, "LB");
        checkOutput("LB be", 32'(obsBE), 32'h8);
        checkOutput("LB data", readData, 32'hFFFF_FF80);
        applyStimulus(1, 0, 3'd4, 32'h103, 32'd0, 2, 32'h80FF_0000, "LBU");
        checkOutput("LBU data", readData, 32'h0000_0080);

        applyStimulus(0, 1, 3'd1, 32'h202, 32'h1234_ABCD, 0, 32'h0, "SH");
        checkOutput("SH write", 32'(obsWrite), 32'd1);
        checkOutput("SH addr", obsAddr, 32'h200);
        checkOutput("SH be", 32'(obsBE), 32'hC);
        checkOutput("SH wdata", obsWD, 32'hABCD_ABCD);
        checkOutput("SH readDataKept", readData, 32'h0000_0080);

        applyStimulus(1, 0, 3'd2, 32'h104, 32'd0, 1000, 32'h5555_5555, "LWtimeout");
        checkOutput("LWtimeout cycles", 32'(obsReqCycles), 32'd4);
        checkOutput("LWtimeout data", readData, 32'd0);

        applyStimulus(1, 0, 3'd2, 32'h108, 32'd0, 0, 32'h0BAD_F00D, "LWpreReset");
        readMemory = 1'b1;
        funct3     = 3'd2;
        address    = 32'h300;
        busReady   = 1'b0;
        @(negedge clk);
        checkOutput("rst busRequestBefore", 32'(busRequest), 32'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst busRequest", 32'(busRequest), 32'd0);
        checkOutput("rst stall", 32'(stall), 32'd0);
        checkOutput("rst readData", readData, 32'd0);
        expRead = 32'd0;
        @(negedge clk);
        reset      = 1'b0;
        readMemory = 1'b0;
        @(negedge clk);
        checkOutput("rst busError", 32'(busError), 32'd0);
        applyStimulus(1, 0, 3'd2, 32'h300, 32'd0, 1, 32'hCAFE_F00D, "LWafterReset");
        checkOutput("LWafterReset data", readData, 32'hCAFE_F00D);

        applyStimulus(1, 0, 3'd2, 32'h101, 32'd0, 0, 32'h1357_9BDF, "LWmis");
`ifdef LSU_MISALIGN_TRAP_EN
        checkOutput("LWmis cycles", 32'(obsReqCycles), 32'd0);
        checkOutput("LWmis data", readData, 32'd0);
`else
        checkOutput("LWmis addr", obsAddr, 32'h100);
        checkOutput("LWmis be", 32'(obsBE), 32'hF);
        checkOutput("LWmis data", readData, 32'h1357_9BDF);
`endif

        applyStimulus(1, 1, 3'd0, 32'h011, 32'h0000_00A5, 0, 32'h0, "SBboth");
        checkOutput("SBboth wdata", obsWD, 32'hA5A5_A5A5);

        for (int i = 0; i < 40; i++) begin
            int kind = int'($urandom_range(0, 2));
            int delay = int'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) delay = 10;
            applyStimulus(kind != 1, kind != 0, 3'($urandom_range(0, 7)), $urandom, $urandom,
                          delay, $urandom, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
